// File: rtl/accel_op_sequencer.sv
// accel_op_sequencer: queues {op, A, B} commands from TinyQV register writes,
// issues them one at a time to the 8-bit accelerator ALU and buffers the results.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   address, data_write   : TinyQV register address and write strobe
//   data_in, data_out     : write data, combinational read data
//   alu_a, alu_b, alu_op  : registered ALU operands and opcode
//   alu_out               : combinational ALU result
//   done                  : one-cycle pulse when a result enters the result FIFO
//
// Optional: `define ACCEL_OP_SEQUENCER_CHAIN_EN turns op[3] into a chain flag.
// A chained command takes operand A from the most recent result.
module accel_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    output logic       done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t        state_q;
    logic [7:0]    stage_a_q;
    logic [7:0]    stage_b_q;
    logic [3:0]    last_op_q;
    logic [19:0]   cmd_mem_q [DEPTH];
    logic [7:0]    res_mem_q [DEPTH];
    logic [PW-1:0] cmd_wp_q;
    logic [PW-1:0] cmd_rp_q;
    logic [PW-1:0] res_wp_q;
    logic [PW-1:0] res_rp_q;
    logic [3:0]    cmd_cnt_q;
    logic [3:0]    cmd_cnt_d;
    logic [3:0]    res_cnt_q;
    logic [3:0]    res_cnt_d;
    logic          ovf_q;
    logic          unf_q;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic [3:0]    alu_op_q;
    logic          done_q;
`ifdef ACCEL_OP_SEQUENCER_CHAIN_EN
    logic [7:0]    chain_q;
`endif

    logic wr_a, wr_b, wr_op, wr_pop, wr_clr;
    logic cmd_empty, cmd_full, res_empty, res_full;
    logic cmd_push, issue, res_push, res_pop, busy;
    logic [19:0] cmd_head;

    assign wr_a   = data_write && (address == 4'd0);
    assign wr_b   = data_write && (address == 4'd1);
    assign wr_op  = data_write && (address == 4'd2);
    assign wr_pop = data_write && (address == 4'd4);
    assign wr_clr = data_write && (address == 4'd6);

    assign cmd_empty = (cmd_cnt_q == 4'd0);
    assign cmd_full  = (cmd_cnt_q == FULL_CNT);
    assign res_empty = (res_cnt_q == 4'd0);
    assign res_full  = (res_cnt_q == FULL_CNT);

    // Full/empty are start-of-cycle values, so a push racing an issue
    // from a full FIFO is still dropped.
    assign cmd_push = wr_op && !cmd_full;
    assign issue    = (state_q == IDLE) && !cmd_empty && !res_full;
    assign res_push = (state_q == WB);
    assign res_pop  = wr_pop && !res_empty;
    assign busy     = (state_q != IDLE) || !cmd_empty;
    assign cmd_head = cmd_mem_q[cmd_rp_q];

    assign cmd_cnt_d = cmd_cnt_q + {3'b000, cmd_push} - {3'b000, issue};
    assign res_cnt_d = res_cnt_q + {3'b000, res_push} - {3'b000, res_pop};

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wp_q] <= {data_in[3:0], stage_a_q, stage_b_q};
        end
        if (res_push) begin
            res_mem_q[res_wp_q] <= alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stage_a_q <= 8'h00;
            stage_b_q <= 8'h00;
            last_op_q <= 4'h0;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            cmd_cnt_q <= 4'd0;
            res_cnt_q <= 4'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_op_q  <= 4'h0;
            done_q    <= 1'b0;
`ifdef ACCEL_OP_SEQUENCER_CHAIN_EN
            chain_q   <= 8'h00;
`endif
        end else begin
            if (wr_a)  stage_a_q <= data_in;
            if (wr_b)  stage_b_q <= data_in;
            if (wr_op) last_op_q <= data_in[3:0];
            if (cmd_push) cmd_wp_q <= cmd_wp_q + PW'(1);
            if (issue)    cmd_rp_q <= cmd_rp_q + PW'(1);
            if (res_push) res_wp_q <= res_wp_q + PW'(1);
            if (res_pop)  res_rp_q <= res_rp_q + PW'(1);
            cmd_cnt_q <= cmd_cnt_d;
            res_cnt_q <= res_cnt_d;
            if (wr_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (wr_op && cmd_full)   ovf_q <= 1'b1;
                if (wr_pop && res_empty) unf_q <= 1'b1;
            end
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        alu_a_q  <= cmd_head[15:8];
                        alu_b_q  <= cmd_head[7:0];
                        alu_op_q <= cmd_head[19:16];
`ifdef ACCEL_OP_SEQUENCER_CHAIN_EN
                        if (cmd_head[19]) begin
                            alu_a_q  <= chain_q;
                            alu_op_q <= {1'b0, cmd_head[18:16]};
                        end
`endif
                        state_q <= EXEC;
                    end
                end
                EXEC: state_q <= WB;
                WB: begin
                    done_q  <= 1'b1;
`ifdef ACCEL_OP_SEQUENCER_CHAIN_EN
                    chain_q <= alu_out;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'd0: data_out = stage_a_q;
            4'd1: data_out = stage_b_q;
            4'd2: data_out = {4'h0, last_op_q};
            4'd3: data_out = res_empty ? 8'h00 : res_mem_q[res_rp_q];
            4'd5: data_out = {1'b0, unf_q, ovf_q, busy,
                              res_full, res_empty, cmd_full, cmd_empty};
            4'd6: data_out = {cmd_cnt_q, res_cnt_q};
            default: data_out = 8'h00;
        endcase
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign done   = done_q;

endmodule

// File: doc/accel_op_sequencer.md
Name: accel_op_sequencer

Overview:
- Command/result sequencer placed directly upstream of the 8-bit accelerator ALU; it is the block that feeds that ALU.
- Takes TinyQV register writes, queues {op, A, B} commands in a FIFO and issues them to the ALU one at a time.
- Captures each ALU result into a result FIFO that software reads back.
- Lets software queue a batch of operations without polling between them.

Parameters:
- DEPTH, 4, entries in each of the command and result FIFOs; power of two, 2..8.

Ports:
- clk  input  1  clock, 64 MHz project clock
- rst_n  input  1  reset, synchronous, active-low
- address  input  4  TinyQV register address
- data_write  input  1  write strobe; data_in valid when high
- data_in  input  8  write data
- data_out  output  8  read data, combinational decode of address
- alu_a  output  8  ALU operand A, registered
- alu_b  output  8  ALU operand B, registered
- alu_op  output  4  ALU opcode, registered
- alu_out  input  8  ALU combinational result
- done  output  1  one-cycle pulse when a result is written to the result FIFO

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFOs emptied; staging A/B and last_op cleared to 0.
  - FSM forced to IDLE; alu_a, alu_b, alu_op and done all 0; sticky flags cleared.
  - An in-flight operation is discarded.
- Register map, write side (acts only when data_write is high):
  - 0: stage_A = data_in.
  - 1: stage_B = data_in.
  - 2: last_op = data_in[3:0]; push {data_in[3:0], stage_A, stage_B} into the command FIFO.
  - 4: pop the result FIFO; data ignored.
  - 6: clear sticky flags.
- Register map, read side:
  - 0: stage_A. 1: stage_B. 2: {4'b0, last_op}.
  - 3: result FIFO head; 0 when empty.
  - 5: status = {1'b0, pop_underflow, cmd_overflow, busy, res_full, res_empty, cmd_full, cmd_empty}.
  - 6: {cmd_count, res_count}, 4 bits each.
  - Any other address reads 0.
- Boundary rules:
  - Push while the command FIFO is full (state at start of cycle): command dropped, cmd_overflow set; it stays set until cleared by a write to 6.
  - Pop while the result FIFO is empty: no change, pop_underflow set.
  - Full/empty are judged at the start of the cycle. A push on the same edge as an FSM command pop is accepted only if the FIFO was not full.
  - A software pop and an FSM result write on the same edge are both performed.
- FSM (IDLE, EXEC, WB):
  - IDLE: if cmd FIFO not empty and res FIFO not full, pop the command, load alu_a/alu_b/alu_op and go to EXEC. Otherwise stay in IDLE and hold the ALU outputs.
  - EXEC: one settling cycle; go to WB.
  - WB: write alu_out into the result FIFO, assert done for this cycle, go to IDLE.
  - busy = (state != IDLE) or cmd FIFO not empty.
  - A full result FIFO stalls issue in IDLE. The result FIFO never overflows.
- Latency and throughput:
  - Push at edge N: command visible at N+1; ALU outputs loaded at N+1 (IDLE->EXEC); result written and done high at N+3; readable at address 3 from N+3.
  - Throughput is one operation per 3 cycles.
- Counts run 0..DEPTH. FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: ACCEL_OP_SEQUENCER_CHAIN_EN.
- Defined:
  - op bit 3 is a chain flag. When set, alu_a is loaded from the most recent captured result (0 after reset) instead of the queued A, and alu_op = {1'b0, op[2:0]}.
  - The chain register updates in WB even if that result is later popped.
- Undefined: op passes through as 4 bits unchanged; no chain register exists.

Test Plan:
- Reset then read addresses 0..6 -> 0, 0, 0, 0, 0, 0x05 (both FIFOs empty), 0x00; alu_a, alu_b, alu_op and done all 0.
- Write A=0x12, B=0x34, op=0 at edge N -> alu_a=0x12, alu_b=0x34, alu_op=0 from N+1; done pulses at N+3 with model ALU (add) result 0x46 at address 3; write 4 pops; status returns to 0x05.
- With the result FIFO stalled (no pops), push DEPTH+1 ops, then DEPTH+2 more:
  - After the first DEPTH+1 pushes: result FIFO becomes full, FSM waits in IDLE, res_full=1.
  - After the further DEPTH+2 pushes: cmd_count=DEPTH, cmd_overflow set.
  - After one pop: exactly one more op completes.
- Pop with empty result FIFO -> pop_underflow set, counts unchanged; write 6 -> flags cleared.
- Assert rst_n low during EXEC -> next cycle: state IDLE, FIFOs empty, no done pulse, alu outputs 0.
- CHAIN_EN: push A=5, B=3, op=0 then B=1, op=8 -> results 8 then 9 (A replaced by previous result); without the macro, op=8 is passed to alu_op as 8.
